// File: rtl/output_signature_compactor_if.sv
// Observed-data and serialized-signature bundle for the output signature compactor.
// The master drives the observed data and requests; the slave (compactor) returns the signature stream.
interface output_signature_compactor_if #(
  parameter int WIDTH = 64
);
  logic             enable;
  logic [WIDTH-1:0] data_in;
  logic             dump_req;
  logic             sig_bit;
  logic             sig_frame;
  logic [7:0]       frame_count;
  logic             overrun;

  modport master (
    output enable, data_in, dump_req,
    input  sig_bit, sig_frame, frame_count, overrun
  );

  modport slave (
    input  enable, data_in, dump_req,
    output sig_bit, sig_frame, frame_count, overrun
  );
endinterface

// File: rtl/output_signature_compactor.sv
// 32-bit MISR that compacts a wide observed bus and periodically (or on request)
// shifts a frozen snapshot of the signature out MSB first.
module output_signature_compactor #(
  parameter int          WIDTH     = 64,
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter int          FRAME_LEN = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  output_signature_compactor_if.slave    bus
);

  localparam int          NSLICE   = (WIDTH + 31) / 32;
  localparam logic [15:0] CNT_LAST = 16'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [31:0] sig_q, sig_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  fc_q, fc_d;
  logic        ovr_q, ovr_d;

  logic [NSLICE*32-1:0] padded;
  logic [31:0]          slice [NSLICE];
  logic [31:0]          fold;
  logic                 fb;
  logic                 trigger;

  always_comb begin
    padded             = '0;
    padded[WIDTH-1:0]  = bus.data_in;
  end

  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
    assign slice[gi] = padded[gi*32 +: 32];
  end

  always_comb begin
    fold = '0;
    for (int i = 0; i < NSLICE; i++) begin
      fold = fold ^ slice[i];
    end
  end

  assign fb      = sig_q[31] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0];
  assign trigger = (cnt_q == CNT_LAST) || bus.dump_req;

  always_comb begin
    sig_d   = sig_q;
    cnt_d   = trigger ? 16'd0 : cnt_q + 16'd1;
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    fc_d    = fc_q;
    ovr_d   = ovr_q;

    if (bus.enable) begin
      sig_d = {sig_q[30:0], fb} ^ fold;
    end

    case (state_q)
      IDLE: begin
        // Snapshot takes the pre-update MISR so later compaction cannot disturb the frame.
        if (trigger) begin
          snap_d  = sig_q;
          idx_d   = 5'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (trigger) begin
          ovr_d = 1'b1;
        end
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          state_d = IDLE;
          fc_d    = fc_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      snap_q  <= '0;
      idx_q   <= '0;
      fc_q    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      fc_q    <= fc_d;
      ovr_q   <= ovr_d;
    end
  end

  // Outputs decode straight from flops so reset clears them without a clock.
  assign bus.sig_frame   = (state_q == SHIFT);
  assign bus.sig_bit     = (state_q == SHIFT) & snap_q[~idx_q];
  assign bus.frame_count = fc_q;
  assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_output_signature_compactor.sv
// Randomized scoreboard bench: a behavioural MISR/frame model queues expected
// signatures, and an independent monitor reassembles and checks each shifted frame.
module tb_output_signature_compactor;

  localparam int          W  = 72;
  localparam int          FL = 40;
  localparam logic [31:0] SD = 32'h0000_0001;

  logic clk;
  logic reset;

  output_signature_compactor_if #(.WIDTH(W)) bus ();

  output_signature_compactor #(
    .WIDTH     (W),
    .SEED      (SD),
    .FRAME_LEN (FL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference model
  logic [31:0] m_sig;
  int          m_cnt;
  int          m_busy;
  logic        m_ovr;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] fold_ref(input logic [W-1:0] d);
    logic [31:0] f = '0;
    for (int i = 0; i < W; i++) f[i % 32] ^= d[i];
    return f;
  endfunction

  task automatic model_reset();
    m_sig  = SD;
    m_cnt  = 0;
    m_busy = 0;
    m_ovr  = 1'b0;
    exp_q.delete();
  endtask

  task automatic cyc(input bit en, input logic [W-1:0] d, input bit dr);
    bit          trig;
    logic        fbv;
    bus.enable   = en;
    bus.data_in  = d;
    bus.dump_req = dr;
    trig = (m_cnt == FL - 1) || dr;
    if (trig && m_busy == 0) begin
      exp_q.push_back(m_sig);
      m_busy = 32;
    end else begin
      if (trig) m_ovr = 1'b1;
      if (m_busy > 0) m_busy--;
    end
    m_cnt = trig ? 0 : m_cnt + 1;
    if (en) begin
      fbv   = m_sig[31] ^ m_sig[21] ^ m_sig[1] ^ m_sig[0];
      m_sig = {m_sig[30:0], fbv} ^ fold_ref(d);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [95:0] r = {$urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Monitor: reassembles frames and pops expectations
  int          frames_seen = 0;
  int          bits        = 0;
  logic [31:0] shreg       = '0;
  logic [31:0] last_frame  = '0;

  always @(negedge clk) begin
    if (!reset) begin
      bits        = 0;
      frames_seen = 0;
    end else if (bus.sig_frame) begin
      shreg = {shreg[30:0], bus.sig_bit};
      bits++;
      if (bits == 32) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", shreg, 32'hxxxx_xxxx);
        end else begin
          chk("frame_signature", shreg, exp_q.pop_front());
        end
        last_frame = shreg;
        frames_seen++;
        bits = 0;
      end
    end else begin
      chk("sig_bit_idle", 32'(bus.sig_bit), 32'd0);
      if (bits != 0) chk("frame_length", 32'(bits), 32'd32);
      bits = 0;
      chk("frame_count", 32'(bus.frame_count), 32'(frames_seen % 256));
    end
  end

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while ((frames_seen < target || bus.sig_frame) && n < budget) begin
      cyc(1'b0, '0, 1'b0);
      n++;
    end
    if (n >= budget) chk("wait_frames_timeout", 32'(frames_seen), 32'(target));
  endtask

  initial begin
    int f0;
    int n;
    bus.enable   = 1'b0;
    bus.data_in  = '0;
    bus.dump_req = 1'b0;
    reset        = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sig_frame", 32'(bus.sig_frame), 32'd0);
    chk("rst_sig_bit", 32'(bus.sig_bit), 32'd0);
    chk("rst_frame_count", 32'(bus.frame_count), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    reset = 1'b1;

    // Automatic dump after FRAME_LEN edges with the seed untouched
    for (int i = 0; i < FL - 1; i++) cyc(1'b0, '0, 1'b0);
    chk("auto_not_yet", 32'(bus.sig_frame), 32'd0);
    cyc(1'b0, '0, 1'b0);
    chk("auto_frame_rise", 32'(bus.sig_frame), 32'd1);
    wait_frames(1, 60);
    chk("seed_frame", last_frame, 32'h0000_0001);
    chk("fc_after_first", 32'(bus.frame_count), 32'd1);

    // One enabled edge with zero data, then an explicit dump
    cyc(1'b1, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    wait_frames(2, 60);
    chk("one_step_frame", last_frame, 32'h0000_0003);

    // 256 accepted frames, no dump requests: frame_count wraps, no overrun
    f0 = frames_seen;
    n  = 0;
    while (frames_seen < f0 + 256 && n < 256 * FL + 200) begin
      cyc(1'($urandom_range(0, 1)), rand_data(), 1'b0);
      n++;
    end
    wait_frames(f0 + 256, 60);
    chk("wrap_count", 32'(bus.frame_count), 32'((f0 + 256) % 256));
    chk("wrap_no_overrun", 32'(bus.overrun), 32'd0);

    // Dump during SHIFT is dropped and makes overrun sticky
    f0 = frames_seen;
    cyc(1'b1, rand_data(), 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1, rand_data(), 1'b0);
    cyc(1'b1, rand_data(), 1'b1);
    chk("overrun_set", 32'(bus.overrun), 32'd1);
    wait_frames(f0 + 1, 60);
    repeat (5) cyc(1'b0, '0, 1'b0);
    chk("overrun_single_frame", 32'(frames_seen), 32'(f0 + 1));
    chk("overrun_sticky", 32'(bus.overrun), 32'd1);

    // Random traffic with occasional dump requests
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 1)), rand_data(), ($urandom_range(0, 15) == 0));
    end
    chk("overrun_model", 32'(bus.overrun), 32'(m_ovr));

    // Asynchronous reset in the middle of a frame
    n = 0;
    while (!bus.sig_frame && n < 200) begin
      cyc(1'b1, rand_data(), 1'b0);
      n++;
    end
    chk("mid_frame_found", 32'(bus.sig_frame), 32'd1);
    for (int i = 0; i < 16; i++) cyc(1'b1, rand_data(), 1'b0);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_sig_frame", 32'(bus.sig_frame), 32'd0);
    chk("async_sig_bit", 32'(bus.sig_bit), 32'd0);
    chk("async_frame_count", 32'(bus.frame_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("post_rst_count", 32'(bus.frame_count), 32'd0);
    chk("post_rst_overrun", 32'(bus.overrun), 32'd0);
    for (int i = 0; i < FL - 1; i++) cyc(1'b0, '0, 1'b0);
    chk("post_rst_not_yet", 32'(bus.sig_frame), 32'd0);
    cyc(1'b0, '0, 1'b0);
    chk("post_rst_frame_rise", 32'(bus.sig_frame), 32'd1);
    wait_frames(1, 60);
    chk("post_rst_seed_frame", last_frame, SD);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_signature_compactor.md
OUTPUT_SIGNATURE_COMPACTOR -- requirements
Module: output_signature_compactor

Interface
REQ-001 SHALL have parameter WIDTH, default 64, width of observed data bus (1..256).
REQ-002 SHALL have parameter SEED, default 32'h0000_0001, MISR reset value.
REQ-003 SHALL have parameter FRAME_LEN, default 1024, cycles between automatic signature dumps (legal 33..65535).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  MISR update enable.
REQ-007 SHALL have port data_in  input  WIDTH  observed design outputs to compact.
REQ-008 SHALL have port dump_req  input  1  single-cycle request for an immediate signature dump.
REQ-009 SHALL have port sig_bit  output  1  serialized signature bit, MSB first.
REQ-010 SHALL have port sig_frame  output  1  high while sig_bit carries a valid signature bit.
REQ-011 SHALL have port frame_count  output  8  number of completed frames, wraps modulo 256.
REQ-012 SHALL have port overrun  output  1  sticky flag, dump request dropped.

Function
REQ-013 SHALL fold data_in into 32 bits as the XOR of all 32-bit slices, zero-padded to a multiple of 32 bits.
REQ-014 SHALL define fb = sig[31]^sig[21]^sig[1]^sig[0] for the 32-bit MISR register sig.
REQ-015 SHALL, on each edge with enable=1, load sig <= {sig[30:0], fb} ^ fold(data_in); with enable=0, sig SHALL hold.
REQ-016 SHALL keep a free-running period counter, 0..FRAME_LEN-1, incrementing every edge regardless of enable.
REQ-017 SHALL generate a trigger on the edge where the counter equals FRAME_LEN-1, or on any edge with dump_req=1.
REQ-018 SHALL reset the period counter to 0 on every trigger edge, whether the trigger is accepted or dropped.
REQ-019 SHALL implement FSM states IDLE and SHIFT.
REQ-020 SHALL, on a trigger in IDLE, capture the pre-update sig value into a 32-bit snapshot register, clear a 5-bit bit index, and go to SHIFT.
REQ-021 SHALL, in SHIFT, drive sig_frame=1 and sig_bit=snapshot[31-index], incrementing index each edge.
REQ-022 SHALL, on the edge where index=31, return to IDLE and increment frame_count (255 wraps to 0).
REQ-023 SHALL assert sig_frame for exactly 32 consecutive cycles per accepted trigger, beginning the cycle after the trigger edge.
REQ-024 SHALL drive sig_bit=0 whenever sig_frame=0.
REQ-025 SHALL, on a trigger while in SHIFT, drop the request, leave the snapshot and index untouched, and set overrun=1 until reset.
REQ-026 SHALL, when dump_req coincides with the automatic trigger, treat both as one trigger.
REQ-027 SHALL continue MISR updates during SHIFT; MISR updates SHALL NOT affect the frame being shifted.

Reset
REQ-028 SHALL, while reset=0, asynchronously force sig=SEED, period counter=0, FSM=IDLE, snapshot=0, index=0, sig_bit=0, sig_frame=0, frame_count=0, overrun=0.
REQ-029 SHALL abort any frame in progress when reset asserts mid-SHIFT, without incrementing frame_count.
REQ-030 SHALL resume counting from 0 on the first clk edge after reset deasserts.

Verification
REQ-031 Default parameters, FRAME_LEN=40, enable=0, release reset -> on the 40th edge, sig_frame rises; bits are 31 zeros then 1; frame_count=1 after 32 cycles.
REQ-032 SEED=1, enable=1 for one edge, data_in=0, then dump_req -> shifted signature = 32'h0000_0003.
REQ-033 SEED=0, WIDTH=64, enable=1 for one edge, data_in=64'hFFFF_FFFF_0000_0000 -> sig = 32'hFFFF_FFFF; dumped frame matches.
REQ-034 dump_req issued 10 cycles into SHIFT -> overrun=1 and stays 1; frame continues unaltered; frame_count increments by 1 only.
REQ-035 Reset pulled low at bit 16 of a frame -> sig_frame and sig_bit go 0 immediately with no clock; frame_count=0 after release.
REQ-036 Issue 256 accepted frames -> frame_count goes 255 then 0; overrun remains 0.
